// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 set-2 key decoder.
//   ps2_state_t  - prefix FSM state (idle, after F0, after E0, after E0 F0)
//   BREAK_CODE   - 8'hF0 break prefix
//   EXT_CODE     - 8'hE0 extended-key prefix
//   LSHIFT_CODE  - 8'h12 left shift make code
//   RSHIFT_CODE  - 8'h59 right shift make code
//   ERR_CHAR     - 8'h78 ('x') pushed for unmapped make codes
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StExt,
        StExtBreak
    } ps2_state_t;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] EXT_CODE    = 8'hE0;
    localparam logic [7:0] LSHIFT_CODE = 8'h12;
    localparam logic [7:0] RSHIFT_CODE = 8'h59;
    localparam logic [7:0] ERR_CHAR    = 8'h78;

    // True for bytes the FSM consumes itself rather than looking up.
    function automatic logic is_control(input logic [7:0] code);
        return (code == BREAK_CODE) || (code == EXT_CODE) ||
               (code == LSHIFT_CODE) || (code == RSHIFT_CODE);
    endfunction

endpackage

// File: rtl/scan_lut.sv
// scan_lut: combinational PS/2 set-2 make code to ASCII lookup.
//   code  (in)  scan byte
//   shift (in)  a shift key is held
//   ascii (out) mapped character, 8'h00 when not mapped
//   hit   (out) code maps to a character under the current parameters
// Parameters: HEX_ONLY restricts letters to A-F; LOWERCASE_EN selects
// lowercase letters when shift is not held.
module scan_lut #(
    parameter int unsigned HEX_ONLY     = 0,
    parameter int unsigned LOWERCASE_EN = 1
) (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       hit
);

    logic       digit_hit;
    logic [3:0] digit_val;
    logic       letter_hit;
    logic [4:0] letter_idx;
    logic       letter_ok;
    logic [7:0] letter_base;

    always_comb begin
        digit_hit = 1'b1;
        digit_val = 4'd0;
        unique case (code)
            8'h45: digit_val = 4'd0;
            8'h16: digit_val = 4'd1;
            8'h1E: digit_val = 4'd2;
            8'h26: digit_val = 4'd3;
            8'h25: digit_val = 4'd4;
            8'h2E: digit_val = 4'd5;
            8'h36: digit_val = 4'd6;
            8'h3D: digit_val = 4'd7;
            8'h3E: digit_val = 4'd8;
            8'h46: digit_val = 4'd9;
            default: digit_hit = 1'b0;
        endcase
    end

    // letter_idx is the offset from 'A'
    always_comb begin
        letter_hit = 1'b1;
        letter_idx = 5'd0;
        unique case (code)
            8'h1C: letter_idx = 5'd0;
            8'h32: letter_idx = 5'd1;
            8'h21: letter_idx = 5'd2;
            8'h23: letter_idx = 5'd3;
            8'h24: letter_idx = 5'd4;
            8'h2B: letter_idx = 5'd5;
            8'h34: letter_idx = 5'd6;
            8'h33: letter_idx = 5'd7;
            8'h43: letter_idx = 5'd8;
            8'h3B: letter_idx = 5'd9;
            8'h42: letter_idx = 5'd10;
            8'h4B: letter_idx = 5'd11;
            8'h3A: letter_idx = 5'd12;
            8'h31: letter_idx = 5'd13;
            8'h44: letter_idx = 5'd14;
            8'h4D: letter_idx = 5'd15;
            8'h15: letter_idx = 5'd16;
            8'h2D: letter_idx = 5'd17;
            8'h1B: letter_idx = 5'd18;
            8'h2C: letter_idx = 5'd19;
            8'h3C: letter_idx = 5'd20;
            8'h2A: letter_idx = 5'd21;
            8'h1D: letter_idx = 5'd22;
            8'h22: letter_idx = 5'd23;
            8'h35: letter_idx = 5'd24;
            8'h1A: letter_idx = 5'd25;
            default: letter_hit = 1'b0;
        endcase
    end

    always_comb begin
        letter_ok   = letter_hit && ((HEX_ONLY == 0) || (letter_idx < 5'd6));
        letter_base = ((LOWERCASE_EN != 0) && !shift) ? 8'h61 : 8'h41;
        ascii       = 8'h00;
        hit         = 1'b0;
        if (digit_hit) begin
            ascii = 8'h30 + {4'h0, digit_val};
            hit   = 1'b1;
        end else if (letter_ok) begin
            ascii = letter_base + {3'b000, letter_idx};
            hit   = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan byte stream to ASCII character queue.
//   clk        (in)  clock, rising edge
//   rst_n      (in)  asynchronous active-low reset
//   code_in    (in)  scan byte
//   code_valid (in)  code_in qualifier, one byte per high cycle
//   out_data   (out) character at queue head (8'h00 when empty)
//   out_valid  (out) queue non-empty
//   out_ready  (in)  consumer pop, taken when out_valid && out_ready
//   shift_held (out) either shift key currently held
//   overflow   (out) sticky: a character was dropped on a full queue
//   count      (out) queue occupancy
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned HEX_ONLY     = 0,
    parameter int unsigned LOWERCASE_EN = 1,
    parameter int unsigned EMIT_ERR     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    code_in,
    input  logic                          code_valid,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          shift_held,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    ps2_state_t state_q;
    logic       lshift_q;
    logic       rshift_q;

    logic [7:0] lut_ascii;
    logic       lut_hit;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       full;
    logic       do_push;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;

    assign shift_held = lshift_q | rshift_q;

    scan_lut #(
        .HEX_ONLY     (HEX_ONLY),
        .LOWERCASE_EN (LOWERCASE_EN)
    ) u_scan_lut (
        .code  (code_in),
        .shift (shift_held),
        .ascii (lut_ascii),
        .hit   (lut_hit)
    );

    // Prefix FSM and shift tracking; only moves on valid bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else if (code_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (code_in == BREAK_CODE) begin
                        state_q <= StBreak;
                    end else if (code_in == EXT_CODE) begin
                        state_q <= StExt;
                    end else if (code_in == LSHIFT_CODE) begin
                        lshift_q <= 1'b1;
                    end else if (code_in == RSHIFT_CODE) begin
                        rshift_q <= 1'b1;
                    end
                end
                StBreak: begin
                    state_q <= StIdle;
                    if (code_in == LSHIFT_CODE) lshift_q <= 1'b0;
                    if (code_in == RSHIFT_CODE) rshift_q <= 1'b0;
                end
                StExt: begin
                    state_q <= (code_in == BREAK_CODE) ? StExtBreak : StIdle;
                end
                StExtBreak: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Only plain make codes seen from idle produce characters.
    always_comb begin
        push      = 1'b0;
        push_data = ERR_CHAR;
        if (code_valid && (state_q == StIdle) && !is_control(code_in)) begin
            if (lut_hit) begin
                push      = 1'b1;
                push_data = lut_ascii;
            end else if (EMIT_ERR != 0) begin
                push = 1'b1;
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push   = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset; out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign out_data = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code_in;
    logic       code_valid;
    logic       out_ready;

    // d0: defaults; d1: hex-only, depth 4; d2: hex-only, uppercase, no error char
    logic [7:0] od0, od1, od2;
    logic       ov0, ov1, ov2;
    logic       sh0, sh1, sh2;
    logic       of0, of1, of2;
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [3:0] cnt2;

    int total = 0;
    int bad   = 0;

    logic [7:0] exq0[$];
    logic [7:0] exq1[$];
    logic [7:0] exq2[$];

    always #5 clk = ~clk;

    ps2_key_decoder u_d0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .out_data   (od0),
        .out_valid  (ov0),
        .out_ready  (out_ready),
        .shift_held (sh0),
        .overflow   (of0),
        .count      (cnt0)
    );

    ps2_key_decoder #(
        .FIFO_DEPTH   (4),
        .HEX_ONLY     (1),
        .LOWERCASE_EN (1),
        .EMIT_ERR     (1)
    ) u_d1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .out_data   (od1),
        .out_valid  (ov1),
        .out_ready  (out_ready),
        .shift_held (sh1),
        .overflow   (of1),
        .count      (cnt1)
    );

    ps2_key_decoder #(
        .FIFO_DEPTH   (8),
        .HEX_ONLY     (1),
        .LOWERCASE_EN (0),
        .EMIT_ERR     (0)
    ) u_d2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .out_data   (od2),
        .out_valid  (ov2),
        .out_ready  (out_ready),
        .shift_held (sh2),
        .overflow   (of2),
        .count      (cnt2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare queue head on every handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov0 && out_ready) begin
                chk("d0 pop", od0, (exq0.size() != 0) ? exq0[0] : 8'hxx);
                if (exq0.size() != 0) void'(exq0.pop_front());
            end
            if (ov1 && out_ready) begin
                chk("d1 pop", od1, (exq1.size() != 0) ? exq1[0] : 8'hxx);
                if (exq1.size() != 0) void'(exq1.pop_front());
            end
            if (ov2 && out_ready) begin
                chk("d2 pop", od2, (exq2.size() != 0) ? exq2[0] : 8'hxx);
                if (exq2.size() != 0) void'(exq2.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the capturing edge.
    task automatic send(input logic [7:0] b);
        code_in    = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    // Expected pushes per instance; negative means no character.
    task automatic ex(input int a, input int b, input int c);
        if (a >= 0) exq0.push_back(a[7:0]);
        if (b >= 0) exq1.push_back(b[7:0]);
        if (c >= 0) exq2.push_back(c[7:0]);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exq0.size() + exq1.size() + exq2.size() == 0) break;
            cycles(1);
        end
        cycles(1);
        chkn({tag, " left in scoreboard"}, exq0.size() + exq1.size() + exq2.size(), 0);
        chkn({tag, " d0 count"}, int'(cnt0), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        code_in    = 8'h00;
        code_valid = 1'b0;
        out_ready  = 1'b1;
        #23;
        chkn("reset count", int'(cnt0), 0);
        chkn("reset out_valid", int'(ov0), 0);
        chk("reset out_data", od0, 8'h00);
        chkn("reset overflow", int'(of0), 0);
        chkn("reset shift", int'(sh0), 0);
        rst_n = 1'b1;
        cycles(1);

        // Make then break of 'A': one character only
        ex(8'h61, 8'h61, 8'h41);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        drain("make-break");

        // Left shift held across one letter
        send(8'h12);
        chkn("lshift held", int'(sh0), 1);
        ex(8'h41, 8'h41, 8'h41);
        send(8'h1C);
        send(8'hF0);
        chkn("shift held in break", int'(sh0), 1);
        send(8'h12);
        chkn("lshift released", int'(sh0), 0);
        ex(8'h61, 8'h61, 8'h41);
        send(8'h1C);
        drain("shift");

        // Digit, hex letter, non-hex letter, unmapped key
        ex(8'h30, 8'h30, 8'h30);
        send(8'h45);
        ex(8'h66, 8'h66, 8'h46);
        send(8'h2B);
        ex(8'h77, 8'h78, -1);
        send(8'h1D);
        ex(8'h78, 8'h78, -1);
        send(8'h76);
        drain("lookup");

        // Extended keys ignored, make and break
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        ex(8'h31, 8'h31, 8'h31);
        send(8'h16);
        drain("extended");

        // Right shift
        send(8'h59);
        chkn("rshift held", int'(sh0), 1);
        ex(8'h51, 8'h78, -1);
        send(8'h15);
        send(8'hF0);
        send(8'h59);
        chkn("rshift released", int'(sh0), 0);
        drain("rshift");

        // Fill with consumer stalled; d1 (depth 4) overflows
        out_ready = 1'b0;
        ex(8'h31, 8'h31, 8'h31);
        send(8'h16);
        ex(8'h32, 8'h32, 8'h32);
        send(8'h1E);
        ex(8'h33, 8'h33, 8'h33);
        send(8'h26);
        ex(8'h34, 8'h34, 8'h34);
        send(8'h25);
        ex(8'h35, -1, 8'h35);
        send(8'h2E);
        chkn("d1 full count", int'(cnt1), 4);
        chkn("d1 overflow", int'(of1), 1);
        chkn("d0 count 5", int'(cnt0), 5);
        chkn("d0 no overflow", int'(of0), 0);
        cycles(2);
        chk("d1 head stable", od1, 8'h31);
        // Push into a full queue on the same edge as a pop
        out_ready = 1'b1;
        ex(8'h36, 8'h36, 8'h36);
        send(8'h36);
        chkn("d1 push+pop full count", int'(cnt1), 4);
        chkn("d0 push+pop count", int'(cnt0), 5);
        drain("overflow");
        chkn("d1 overflow sticky", int'(of1), 1);

        // Reset after a break prefix discards it
        send(8'hF0);
        rst_n = 1'b0;
        #2;
        chkn("mid reset overflow", int'(of1), 0);
        chkn("mid reset d1 count", int'(cnt1), 0);
        rst_n = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        ex(8'h61, 8'h61, 8'h41);
        send(8'h1C);
        chkn("post reset count", int'(cnt0), 1);
        chk("post reset head", od0, 8'h61);
        chkn("post reset overflow", int'(of1), 0);
        out_ready = 1'b1;
        drain("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
